// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: fetch state encoding, bubble instruction and PC increment.
package mips_pipe_pkg;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_INC            = 4;

endpackage

// File: rtl/if_stage_ctrl_if.sv
// Fetch-stage bundle: hazard controls and imem data in, fetch address and IF/ID register out.
interface if_stage_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                stall;
  logic                flush;
  logic [PC_WIDTH-1:0] branch_target;
  logic                halt;
  logic [31:0]         imem_instr;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         if_id_instr;
  logic [PC_WIDTH-1:0] if_id_pc_plus4;
  logic                if_id_valid;
  logic                halted;

  modport master (
    output stall, flush, branch_target, halt, imem_instr,
    input  pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted
  );

  modport slave (
    input  stall, flush, branch_target, halt, imem_instr,
    output pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted
  );
endinterface

// File: rtl/perf_sat_counter.sv
// Saturating event counter: increments on i_inc, sticks at all-ones.
module perf_sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);
  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (i_inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_count = count_q;
endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch stage control: PC and IF/ID register with flush > stall > halt > advance priority.
// Optional saturating stall/flush counters are built when PIPE_PERF_CNT_EN is defined.
module if_stage_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = DEFAULT_NOP_INSTR,
  parameter int unsigned         CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  if_stage_ctrl_if.slave       bus,
  output logic [CNT_WIDTH-1:0] o_stall_cnt,
  output logic [CNT_WIDTH-1:0] o_flush_cnt
);
  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [31:0]         instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_seq;

  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_seq = pc_q + PC_WIDTH'(PC_INC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    unique case (state_q)
      StRun: begin
        if (bus.flush) begin
          pc_d       = {bus.branch_target[PC_WIDTH-1:2], 2'b00};
          instr_d    = NOP_INSTR;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
        end else if (bus.stall) begin
          // Hold PC and IF/ID, including valid.
        end else if (bus.halt) begin
          instr_d    = NOP_INSTR;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
          state_d    = StHalted;
        end else begin
          pc_d       = pc_seq;
          instr_d    = bus.imem_instr;
          pc_plus4_d = pc_seq;
          valid_d    = 1'b1;
        end
      end
      StHalted: begin
        instr_d    = NOP_INSTR;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end
    endcase
  end

  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc_plus4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.halted         = (state_q == StHalted);

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc, flush_inc;

  assign stall_inc = (state_q == StRun) && bus.stall && !bus.flush;
  assign flush_inc = (state_q == StRun) && bus.flush;

  perf_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (stall_inc),
    .o_count (o_stall_cnt)
  );

  perf_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (flush_inc),
    .o_count (o_flush_cnt)
  );
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_if_stage_ctrl;
  localparam int unsigned CW = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  if_stage_ctrl_if #(.PC_WIDTH(32)) bus ();

  // Instruction memory: each word encodes its own address.
  assign bus.imem_instr = 32'h1111_0000 + bus.pc;

  if_stage_ctrl #(
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the architecturally visible fetch state.
  logic [31:0]   m_pc, m_instr, m_pc4;
  logic          m_valid, m_halted;
  logic [CW-1:0] m_sc, m_fc;

  function automatic void model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_sc = '0; m_fc = '0;
  endfunction

  function automatic void model_bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock edge with the given hazard inputs; the model is advanced alongside.
  task automatic tick(input logic st, input logic fl, input logic [31:0] bt, input logic ht);
    bus.stall = st; bus.flush = fl; bus.branch_target = bt; bus.halt = ht;
    @(posedge clk);
    if (m_halted) begin
      model_bubble();
    end else if (fl) begin
      m_pc = bt & ~32'd3;
      model_bubble();
      if (CNT_EN && m_fc != '1) m_fc = m_fc + 1'b1;
    end else if (st) begin
      if (CNT_EN && m_sc != '1) m_sc = m_sc + 1'b1;
    end else if (ht) begin
      model_bubble();
      m_halted = 1'b1;
    end else begin
      m_instr = 32'h1111_0000 + m_pc;
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
    end
    #1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.halt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests += 7;
    if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.pc); end
    if (bus.if_id_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr: got %h want 0", bus.if_id_instr);
    end
    if (bus.if_id_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc4: got %h want 0", bus.if_id_pc_plus4);
    end
    if (bus.if_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus.if_id_valid);
    end
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_scnt: got %0d want 0", stall_cnt); end
    if (flush_cnt !== '0) begin n_fail++; $display("FAIL reset_fcnt: got %0d want 0", flush_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_advance();
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      n_tests += 4;
      if (bus.pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL adv_pc[%0d]: got %h want %h", i, bus.pc, 4 * i);
      end
      if (bus.if_id_instr !== 32'h1111_0000 + 32'(4 * (i - 1))) begin
        n_fail++; $display("FAIL adv_instr[%0d]: got %h want %h", i, bus.if_id_instr,
                           32'h1111_0000 + 32'(4 * (i - 1)));
      end
      if (bus.if_id_pc_plus4 !== 32'(4 * i)) begin
        n_fail++; $display("FAIL adv_pc4[%0d]: got %h want %h", i, bus.if_id_pc_plus4, 4 * i);
      end
      if (bus.if_id_valid !== 1'b1) begin
        n_fail++; $display("FAIL adv_valid[%0d]: got %b want 1", i, bus.if_id_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [CW-1:0] exp_sc;
    reset_dut();
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    n_tests += 4;
    if (bus.pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc: got %h want 8", bus.pc); end
    if (bus.if_id_instr !== 32'h1111_0004) begin
      n_fail++; $display("FAIL stall_instr: got %h want 11110004", bus.if_id_instr);
    end
    if (bus.if_id_pc_plus4 !== 32'h8) begin
      n_fail++; $display("FAIL stall_pc4: got %h want 8", bus.if_id_pc_plus4);
    end
    if (bus.if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_valid: got %b want 1", bus.if_id_valid);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    exp_sc = CNT_EN ? CW'(2) : '0;
    n_tests += 2;
    if (bus.pc !== 32'hC) begin n_fail++; $display("FAIL stall_release_pc: got %h want c", bus.pc); end
    if (stall_cnt !== exp_sc) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_sc);
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] exp_fc;
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    n_tests += 4;
    if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL flush_pc: got %h want 100", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b want 0", bus.if_id_valid);
    end
    if (bus.if_id_instr !== 32'h0) begin
      n_fail++; $display("FAIL flush_instr: got %h want 0", bus.if_id_instr);
    end
    if (bus.if_id_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL flush_pc4: got %h want 0", bus.if_id_pc_plus4);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    exp_fc = CNT_EN ? CW'(1) : '0;
    n_tests += 3;
    if (bus.if_id_instr !== 32'h1111_0100) begin
      n_fail++; $display("FAIL flush_fetch_instr: got %h want 11110100", bus.if_id_instr);
    end
    if (bus.if_id_pc_plus4 !== 32'h104) begin
      n_fail++; $display("FAIL flush_fetch_pc4: got %h want 104", bus.if_id_pc_plus4);
    end
    if (flush_cnt !== exp_fc) begin
      n_fail++; $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, exp_fc);
    end
  endtask

  task automatic test_stall_flush();
    logic [CW-1:0] exp_sc, exp_fc;
    tick(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    exp_sc = CNT_EN ? CW'(2) : '0;
    exp_fc = CNT_EN ? CW'(2) : '0;
    n_tests += 4;
    if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL sf_pc: got %h want 200", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL sf_valid: got %b want 0", bus.if_id_valid);
    end
    if (stall_cnt !== exp_sc) begin
      n_fail++; $display("FAIL sf_scnt: got %0d want %0d", stall_cnt, exp_sc);
    end
    if (flush_cnt !== exp_fc) begin
      n_fail++; $display("FAIL sf_fcnt: got %0d want %0d", flush_cnt, exp_fc);
    end
  endtask

  task automatic test_halt();
    logic [CW-1:0] exp_fc;
    tick(1'b0, 1'b1, 32'h0000_0018, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests += 3;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
    if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL halt_pc: got %h want 20", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_valid: got %b want 0", bus.if_id_valid);
    end
    tick(1'b0, 1'b1, 32'h0000_0400, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    exp_fc = CNT_EN ? CW'(3) : '0;
    n_tests += 4;
    if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL halt_hold_pc: got %h want 20", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_hold_valid: got %b want 0", bus.if_id_valid);
    end
    if (bus.halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold_flag: got %b want 1", bus.halted);
    end
    if (flush_cnt !== exp_fc) begin
      n_fail++; $display("FAIL halt_fcnt: got %0d want %0d", flush_cnt, exp_fc);
    end
    // Assert reset between edges: effect must be visible before the next clock.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests += 2;
    if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL async_rst_pc: got %h want 0", bus.pc); end
    if (bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_halted: got %b want 0", bus.halted);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    n_tests += 1;
    if (bus.pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_start_pc: got %h want fffffffc", bus.pc);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests += 4;
    if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", bus.pc); end
    if (bus.if_id_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc4: got %h want 0", bus.if_id_pc_plus4);
    end
    if (bus.if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_valid: got %b want 1", bus.if_id_valid);
    end
    if (bus.if_id_instr !== 32'h1110_FFFC) begin
      n_fail++; $display("FAIL wrap_instr: got %h want 1110fffc", bus.if_id_instr);
    end
  endtask

  task automatic test_random();
    logic st, fl, ht;
    logic [31:0] bt;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) reset_dut();
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      ht = ($urandom_range(0, 47) == 0);
      bt = $urandom;
      tick(st, fl, bt, ht);
      n_tests += 7;
      if (bus.pc !== m_pc) begin
        n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.pc, m_pc);
      end
      if (bus.if_id_instr !== m_instr) begin
        n_fail++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, bus.if_id_instr, m_instr);
      end
      if (bus.if_id_pc_plus4 !== m_pc4) begin
        n_fail++; $display("FAIL rnd_pc4[%0d]: got %h want %h", i, bus.if_id_pc_plus4, m_pc4);
      end
      if (bus.if_id_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.if_id_valid, m_valid);
      end
      if (bus.halted !== m_halted) begin
        n_fail++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, bus.halted, m_halted);
      end
      if (stall_cnt !== m_sc) begin
        n_fail++; $display("FAIL rnd_scnt[%0d]: got %0d want %0d", i, stall_cnt, m_sc);
      end
      if (flush_cnt !== m_fc) begin
        n_fail++; $display("FAIL rnd_fcnt[%0d]: got %0d want %0d", i, flush_cnt, m_fc);
      end
    end
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.halt  = 1'b0;
    bus.branch_target = 32'h0;
    test_reset();
    test_advance();
    test_stall();
    test_flush();
    test_stall_flush();
    test_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
